// File: rtl/dvp_capture_win.sv
// DVP camera capture front end: beat packing, start-up frame skip,
// frame-gated crop window and window-relative pixel addressing.
module dvp_capture_win #(
   parameter int DW          = 8,
   parameter int BPP         = 2,
   parameter int AW          = 11,
   parameter int SKIP_FRAMES = 10
) (
   input  logic               PCLK,
   input  logic               Rst_n,
   input  logic               En,
   input  logic               Swap,
   input  logic [AW-1:0]      CropX0,
   input  logic [AW-1:0]      CropY0,
   input  logic [AW-1:0]      CropW,
   input  logic [AW-1:0]      CropH,
   input  logic               Vsync,
   input  logic               Href,
   input  logic [DW-1:0]      Data,
   output logic               DataValid,
   output logic [DW*BPP-1:0]  DataPixel,
   output logic [AW-1:0]      Xaddr,
   output logic [AW-1:0]      Yaddr,
   output logic               Sof,
   output logic               LineEnd,
   output logic               LineErr,
   output logic               Capturing,
   output logic [15:0]        FrameCnt
);

   localparam int PW  = DW * BPP;
   localparam int PHW = (BPP > 1) ? $clog2(BPP) : 1;
   localparam logic [PHW-1:0] PH_LAST = PHW'(BPP - 1);
   localparam logic [AW-1:0]  C_MAX   = '1;
   localparam logic [8:0]     SKIP_N  = 9'(SKIP_FRAMES);

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      SKIP,
      CAPTURE
   } state_t;

   state_t state;
   state_t state_nx;

   logic          rv;
   logic          rh;
   logic          rh_d;
   logic [DW-1:0] rd;

   logic          fb;
   logic          href_end;
   logic          line_done;

   logic          sh_swap;
   logic [AW-1:0] sh_x0;
   logic [AW-1:0] sh_y0;
   logic [AW-1:0] sh_w;
   logic [AW-1:0] sh_h;

   logic [7:0]    skip_cnt;
   logic          skip_hit;
   logic          capture;
   logic          active;
   logic          skipping;

   logic [PHW-1:0] phase;
   logic [PW-1:0]  acc;
   logic [PW-1:0]  pix;
   logic           pix_done;
   logic [AW-1:0]  col;
   logic [AW-1:0]  row;

   logic [AW:0]    x_end;
   logic [AW:0]    y_end;
   logic           x_in;
   logic           y_in;
   logic           emit;

   logic           sof_pend;
   logic           line_px;

   // Input registers and edge terms
   always_ff @(posedge PCLK or negedge Rst_n) begin
      if (!Rst_n) begin
         rv   <= 1'b0;
         rh   <= 1'b0;
         rh_d <= 1'b0;
         rd   <= '0;
      end else begin
         rv   <= Vsync;
         rh   <= Href;
         rh_d <= rh;
         rd   <= Data;
      end
   end

   assign fb        = ~rv & Vsync;
   assign href_end  = rh & ~Href;
   assign line_done = rh_d & ~rh;

   // Frame-stable copies of the run-time controls
   always_ff @(posedge PCLK or negedge Rst_n) begin
      if (!Rst_n) begin
         sh_swap <= 1'b0;
         sh_x0   <= '0;
         sh_y0   <= '0;
         sh_w    <= '0;
         sh_h    <= '0;
      end else if (fb) begin
         sh_swap <= Swap;
         sh_x0   <= CropX0;
         sh_y0   <= CropY0;
         sh_w    <= CropW;
         sh_h    <= CropH;
      end
   end

   always_ff @(posedge PCLK or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   assign skip_hit = ({1'b0, skip_cnt} + 9'd1) == SKIP_N;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (En) state_nx = SYNC;
         end
         SYNC: begin
            if (!En)
               state_nx = IDLE;
            else if (fb)
               state_nx = (SKIP_FRAMES == 0) ? CAPTURE : SKIP;
         end
         SKIP: begin
            if (!En)
               state_nx = IDLE;
            else if (fb && skip_hit)
               state_nx = CAPTURE;
         end
         CAPTURE: begin
            if (fb && !En) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      capture  = 1'b0;
      active   = 1'b0;
      skipping = 1'b0;
      unique case (state)
         IDLE:    ;
         SYNC:    active = 1'b1;
         SKIP: begin
            active   = 1'b1;
            skipping = 1'b1;
         end
         CAPTURE: begin
            active  = 1'b1;
            capture = 1'b1;
         end
         default: ;
      endcase
   end

   assign Capturing = capture;

   always_ff @(posedge PCLK or negedge Rst_n) begin
      if (!Rst_n) begin
         skip_cnt <= '0;
      end else if (!skipping) begin
         skip_cnt <= '0;
      end else if (fb) begin
         skip_cnt <= skip_cnt + 8'd1;
      end
   end

   // Beat phase and pixel assembly
   assign pix_done = rh && (phase == PH_LAST);

   always_ff @(posedge PCLK or negedge Rst_n) begin
      if (!Rst_n) begin
         phase <= '0;
      end else if (!rh || phase == PH_LAST) begin
         phase <= '0;
      end else begin
         phase <= phase + PHW'(1);
      end
   end

   always_ff @(posedge PCLK or negedge Rst_n) begin
      if (!Rst_n) begin
         acc <= '0;
      end else if (rh) begin
         for (int k = 0; k < BPP; k++) begin
            if (phase == PHW'(k)) begin
               if (sh_swap)
                  acc[k*DW +: DW] <= rd;
               else
                  acc[(BPP-1-k)*DW +: DW] <= rd;
            end
         end
      end
   end

   // The final beat is still in rd, so splice it in directly
   always_comb begin
      pix = acc;
      if (sh_swap)
         pix[(BPP-1)*DW +: DW] = rd;
      else
         pix[0 +: DW] = rd;
   end

   always_ff @(posedge PCLK or negedge Rst_n) begin
      if (!Rst_n) begin
         col <= '0;
      end else if (!rh) begin
         col <= '0;
      end else if (pix_done && col != C_MAX) begin
         col <= col + AW'(1);
      end
   end

   always_ff @(posedge PCLK or negedge Rst_n) begin
      if (!Rst_n) begin
         row <= '0;
      end else if (rv) begin
         row <= '0;
      end else if (href_end && row != C_MAX) begin
         row <= row + AW'(1);
      end
   end

   assign x_end = {1'b0, sh_x0} + {1'b0, sh_w};
   assign y_end = {1'b0, sh_y0} + {1'b0, sh_h};
   assign x_in  = (col >= sh_x0) &&
                  (sh_w == '0 || {1'b0, col} < x_end);
   assign y_in  = (row >= sh_y0) &&
                  (sh_h == '0 || {1'b0, row} < y_end);

   assign emit = pix_done && capture && x_in && y_in &&
                 (col != C_MAX) && (row != C_MAX);

   always_ff @(posedge PCLK or negedge Rst_n) begin
      if (!Rst_n) begin
         DataValid <= 1'b0;
         DataPixel <= '0;
         Xaddr     <= '0;
         Yaddr     <= '0;
         Sof       <= 1'b0;
         FrameCnt  <= '0;
      end else begin
         DataValid <= emit;
         Sof       <= emit & sof_pend;
         if (emit) begin
            DataPixel <= pix;
            Xaddr     <= col - sh_x0;
            Yaddr     <= row - sh_y0;
            if (sof_pend) FrameCnt <= FrameCnt + 16'd1;
         end
      end
   end

   always_ff @(posedge PCLK or negedge Rst_n) begin
      if (!Rst_n) begin
         sof_pend <= 1'b0;
      end else if (fb) begin
         sof_pend <= 1'b1;
      end else if (emit) begin
         sof_pend <= 1'b0;
      end
   end

   // Line markers, reported the cycle after rH has fallen
   always_ff @(posedge PCLK or negedge Rst_n) begin
      if (!Rst_n) begin
         line_px <= 1'b0;
         LineEnd <= 1'b0;
         LineErr <= 1'b0;
      end else begin
         LineEnd <= line_done & line_px;
         LineErr <= line_done & active & (phase != '0);
         if (emit)
            line_px <= 1'b1;
         else if (line_done)
            line_px <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dvp_capture_win.sv
// Randomized frame stimulus for dvp_capture_win, checked against an
// event-level model of skip, crop, addressing and line markers.
`timescale 1ns/1ps
module tb_dvp_capture_win;

   localparam int DW   = 8;
   localparam int BPP  = 2;
   localparam int AW   = 11;
   localparam int SKIP = 2;
   localparam int PW   = DW * BPP;

   logic          PCLK   = 1'b0;
   logic          Rst_n  = 1'b0;
   logic          En     = 1'b0;
   logic          Swap   = 1'b0;
   logic [AW-1:0] CropX0 = '0;
   logic [AW-1:0] CropY0 = '0;
   logic [AW-1:0] CropW  = '0;
   logic [AW-1:0] CropH  = '0;
   logic          Vsync  = 1'b0;
   logic          Href   = 1'b0;
   logic [DW-1:0] Data   = '0;

   logic          DataValid;
   logic [PW-1:0] DataPixel;
   logic [AW-1:0] Xaddr;
   logic [AW-1:0] Yaddr;
   logic          Sof;
   logic          LineEnd;
   logic          LineErr;
   logic          Capturing;
   logic [15:0]   FrameCnt;

   dvp_capture_win #(
      .DW(DW), .BPP(BPP), .AW(AW), .SKIP_FRAMES(SKIP)
   ) dut (
      .PCLK(PCLK), .Rst_n(Rst_n), .En(En), .Swap(Swap),
      .CropX0(CropX0), .CropY0(CropY0),
      .CropW(CropW), .CropH(CropH),
      .Vsync(Vsync), .Href(Href), .Data(Data),
      .DataValid(DataValid), .DataPixel(DataPixel),
      .Xaddr(Xaddr), .Yaddr(Yaddr), .Sof(Sof),
      .LineEnd(LineEnd), .LineErr(LineErr),
      .Capturing(Capturing), .FrameCnt(FrameCnt)
   );

   always #5 PCLK = ~PCLK;

   typedef struct packed {
      int            cyc;
      logic          ln;
      logic          sof;
      logic [15:0]   fc;
      logic [AW-1:0] x;
      logic [AW-1:0] y;
      logic [PW-1:0] pix;
      logic          fin;
      logic          err;
   } ev_t;

   ev_t obs[$];
   ev_t exq[$];
   int  cyc = 0;
   int  vectors = 0;
   int  miscompares = 0;
   int  exp_fc = 0;
   bit  first_px = 1'b0;
   bit  use_seq = 1'b0;

   always @(posedge PCLK) cyc <= cyc + 1;

   always @(negedge PCLK) begin
      if (Rst_n) begin
         if (DataValid)
            obs.push_back(ev_t'{cyc, 1'b0, Sof, FrameCnt, Xaddr,
                                Yaddr, DataPixel, 1'b0, 1'b0});
         if (LineEnd || LineErr)
            obs.push_back(ev_t'{cyc, 1'b1, 1'b0, 16'd0, AW'(0),
                                AW'(0), PW'(0), LineEnd, LineErr});
      end
   end

   // One line: drive beats, then predict its pixels and line marker
   task automatic drive_line(input int row, input int nb,
                             input bit cap, input bit act, input bit sw,
                             input int x0, input int y0,
                             input int w, input int h,
                             inout int bidx);
      logic [DW-1:0] beats[$];
      int            edges[$];
      logic [PW-1:0] v;
      int            s;
      bit            had;
      bit            bad;
      for (int i = 0; i < nb; i++) begin
         @(negedge PCLK);
         Href = 1'b1;
         if (use_seq)
            Data = DW'(((bidx % 15) + 1) * 17);
         else
            Data = DW'($urandom);
         bidx++;
         beats.push_back(Data);
         edges.push_back(cyc + 1);
      end
      @(negedge PCLK);
      Href = 1'b0;
      Data = DW'($urandom);
      had = 1'b0;
      for (int p = 0; p < nb / BPP; p++) begin
         v = '0;
         for (int k = 0; k < BPP; k++) begin
            s = sw ? k : BPP - 1 - k;
            v[s*DW +: DW] = beats[p*BPP + k];
         end
         if (cap && p >= x0 && (w == 0 || p < x0 + w) &&
             row >= y0 && (h == 0 || row < y0 + h)) begin
            if (first_px) exp_fc++;
            exq.push_back(ev_t'{edges[p*BPP + BPP - 1] + 1, 1'b0,
                                first_px, 16'(exp_fc), AW'(p - x0),
                                AW'(row - y0), v, 1'b0, 1'b0});
            first_px = 1'b0;
            had = 1'b1;
         end
      end
      bad = act && (nb % BPP != 0);
      if (nb > 0 && (had || bad))
         exq.push_back(ev_t'{edges[nb-1] + 2, 1'b1, 1'b0, 16'd0,
                             AW'(0), AW'(0), PW'(0), had, bad});
      repeat ($urandom_range(2, 5)) @(negedge PCLK);
   endtask

   task automatic drive_frame(input int nl, input int nb,
                              input int bad_line, input bit cap,
                              input bit act, input bit mid_swap,
                              input bit mid_drop);
      bit sw;
      int x0, y0, w, h;
      int bidx;
      bidx = 0;
      @(negedge PCLK);
      Vsync = 1'b1;
      sw = Swap;
      x0 = int'(CropX0);
      y0 = int'(CropY0);
      w  = int'(CropW);
      h  = int'(CropH);
      first_px = 1'b1;
      repeat (3) @(negedge PCLK);
      Vsync = 1'b0;
      repeat (4) @(negedge PCLK);
      for (int r = 0; r < nl; r++) begin
         drive_line(r, (r == bad_line) ? nb - 1 : nb, cap, act, sw,
                    x0, y0, w, h, bidx);
         if (r == 0 && mid_swap) Swap = ~Swap;
         if (r == 0 && mid_drop) En = 1'b0;
      end
      repeat (4) @(negedge PCLK);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge PCLK);
      vectors++;
      if ({DataValid, DataPixel, Xaddr, Yaddr, Sof, LineEnd, LineErr,
           Capturing, FrameCnt} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got %b %h %h %h %b %b %b %b %h want all 0",
                  DataValid, DataPixel, Xaddr, Yaddr, Sof, LineEnd,
                  LineErr, Capturing, FrameCnt);
      end
      Rst_n = 1'b1;
      repeat (2) @(negedge PCLK);
   endtask

   task automatic test_skip_capture();
      int npx, nln;
      obs.delete(); exq.delete();
      use_seq = 1'b1;
      exp_fc = 0;
      En = 1'b1;
      repeat (2) @(negedge PCLK);
      drive_frame(3, 8, -1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive_frame(3, 8, -1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive_frame(3, 8, -1, 1'b1, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (obs.size() != exq.size()) begin
         miscompares++;
         $display("FAIL skip_events got %0d want %0d", obs.size(), exq.size());
      end
      foreach (exq[i]) begin
         vectors++;
         if (i >= obs.size() || obs[i] !== exq[i]) begin
            miscompares++;
            $display("FAIL skip_ev%0d got %h want %h", i,
                     (i < obs.size()) ? obs[i] : '0, exq[i]);
         end
      end
      npx = 0; nln = 0;
      foreach (obs[i]) if (obs[i].ln) nln++; else npx++;
      vectors++;
      if (npx != 12) begin
         miscompares++;
         $display("FAIL skip_pixels got %0d want 12", npx);
      end
      vectors++;
      if (nln != 3) begin
         miscompares++;
         $display("FAIL skip_lineends got %0d want 3", nln);
      end
      vectors++;
      if (obs.size() == 0 || obs[0].pix !== 16'h1122 || obs[0].x !== 0 ||
          obs[0].y !== 0 || obs[0].sof !== 1'b1 || obs[0].fc !== 16'd1) begin
         miscompares++;
         $display("FAIL skip_first got %h want pix 1122 x0 y0 sof fc1",
                  (obs.size() > 0) ? obs[0] : '0);
      end
      vectors++;
      if (Capturing !== 1'b1) begin
         miscompares++;
         $display("FAIL skip_capturing got %b want 1", Capturing);
      end
   endtask

   task automatic test_swap();
      obs.delete(); exq.delete();
      use_seq = 1'b1;
      Swap = 1'b1;
      drive_frame(3, 8, -1, 1'b1, 1'b1, 1'b1, 1'b0);
      drive_frame(3, 8, -1, 1'b1, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (obs.size() != exq.size()) begin
         miscompares++;
         $display("FAIL swap_events got %0d want %0d", obs.size(), exq.size());
      end
      foreach (exq[i]) begin
         vectors++;
         if (i >= obs.size() || obs[i] !== exq[i]) begin
            miscompares++;
            $display("FAIL swap_ev%0d got %h want %h", i,
                     (i < obs.size()) ? obs[i] : '0, exq[i]);
         end
      end
      vectors++;
      if (obs.size() == 0 || obs[0].pix !== 16'h2211) begin
         miscompares++;
         $display("FAIL swap_first got %h want 2211",
                  (obs.size() > 0) ? obs[0].pix : 16'h0);
      end
   endtask

   task automatic test_crop();
      int npx;
      obs.delete(); exq.delete();
      use_seq = 1'b0;
      Swap = 1'b0;
      CropX0 = 1; CropY0 = 1; CropW = 2; CropH = 1;
      drive_frame(3, 8, -1, 1'b1, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (obs.size() != exq.size()) begin
         miscompares++;
         $display("FAIL crop_events got %0d want %0d", obs.size(), exq.size());
      end
      foreach (exq[i]) begin
         vectors++;
         if (i >= obs.size() || obs[i] !== exq[i]) begin
            miscompares++;
            $display("FAIL crop_ev%0d got %h want %h", i,
                     (i < obs.size()) ? obs[i] : '0, exq[i]);
         end
      end
      npx = 0;
      foreach (obs[i]) if (!obs[i].ln) npx++;
      vectors++;
      if (npx != 2 || obs.size() != 3) begin
         miscompares++;
         $display("FAIL crop_count got %0d px %0d ev want 2 px 3 ev",
                  npx, obs.size());
      end
   endtask

   task automatic test_partial_line();
      int nerr;
      obs.delete(); exq.delete();
      CropX0 = 0; CropY0 = 0; CropW = 0; CropH = 0;
      drive_frame(2, 8, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (obs.size() != exq.size()) begin
         miscompares++;
         $display("FAIL partial_events got %0d want %0d", obs.size(), exq.size());
      end
      foreach (exq[i]) begin
         vectors++;
         if (i >= obs.size() || obs[i] !== exq[i]) begin
            miscompares++;
            $display("FAIL partial_ev%0d got %h want %h", i,
                     (i < obs.size()) ? obs[i] : '0, exq[i]);
         end
      end
      nerr = 0;
      foreach (obs[i]) if (obs[i].err) nerr++;
      vectors++;
      if (nerr != 1) begin
         miscompares++;
         $display("FAIL partial_lineerr got %0d want 1", nerr);
      end
   endtask

   task automatic test_random();
      obs.delete(); exq.delete();
      for (int f = 0; f < 5; f++) begin
         Swap   = 1'($urandom);
         CropX0 = AW'($urandom_range(0, 3));
         CropY0 = AW'($urandom_range(0, 2));
         CropW  = AW'($urandom_range(0, 4));
         CropH  = AW'($urandom_range(0, 3));
         drive_frame($urandom_range(1, 4), BPP * $urandom_range(1, 6),
                     $urandom_range(0, 4) - 1, 1'b1, 1'b1,
                     1'($urandom), 1'b0);
      end
      vectors++;
      if (obs.size() != exq.size()) begin
         miscompares++;
         $display("FAIL random_events got %0d want %0d", obs.size(), exq.size());
      end
      foreach (exq[i]) begin
         vectors++;
         if (i >= obs.size() || obs[i] !== exq[i]) begin
            miscompares++;
            $display("FAIL random_ev%0d got %h want %h", i,
                     (i < obs.size()) ? obs[i] : '0, exq[i]);
         end
      end
   endtask

   task automatic test_en_drop();
      obs.delete(); exq.delete();
      Swap = 1'b0;
      CropX0 = 0; CropY0 = 0; CropW = 0; CropH = 0;
      drive_frame(3, 6, -1, 1'b1, 1'b1, 1'b0, 1'b1);
      drive_frame(2, 6, 1, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (Capturing !== 1'b0) begin
         miscompares++;
         $display("FAIL endrop_idle got %b want 0", Capturing);
      end
      En = 1'b1;
      repeat (2) @(negedge PCLK);
      drive_frame(2, 6, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive_frame(2, 6, -1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive_frame(2, 6, -1, 1'b1, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (obs.size() != exq.size()) begin
         miscompares++;
         $display("FAIL endrop_events got %0d want %0d", obs.size(), exq.size());
      end
      foreach (exq[i]) begin
         vectors++;
         if (i >= obs.size() || obs[i] !== exq[i]) begin
            miscompares++;
            $display("FAIL endrop_ev%0d got %h want %h", i,
                     (i < obs.size()) ? obs[i] : '0, exq[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge PCLK);
      Href = 1'b1;
      Data = DW'($urandom);
      @(negedge PCLK);
      Data = DW'($urandom);
      @(negedge PCLK);
      Rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge PCLK);
         vectors++;
         if ({DataValid, DataPixel, Xaddr, Yaddr, Sof, LineEnd, LineErr,
              Capturing, FrameCnt} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs%0d got %b %h %b %h want all 0",
                     i, DataValid, DataPixel, Capturing, FrameCnt);
         end
      end
      Href = 1'b0;
      @(negedge PCLK);
      Rst_n = 1'b1;
      obs.delete(); exq.delete();
      exp_fc = 0;
      repeat (2) @(negedge PCLK);
      drive_frame(2, 6, -1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive_frame(2, 6, -1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive_frame(2, 6, -1, 1'b1, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (obs.size() != exq.size()) begin
         miscompares++;
         $display("FAIL midreset_events got %0d want %0d", obs.size(), exq.size());
      end
      foreach (exq[i]) begin
         vectors++;
         if (i >= obs.size() || obs[i] !== exq[i]) begin
            miscompares++;
            $display("FAIL midreset_ev%0d got %h want %h", i,
                     (i < obs.size()) ? obs[i] : '0, exq[i]);
         end
      end
      vectors++;
      if (obs.size() == 0 || obs[0].fc !== 16'd1) begin
         miscompares++;
         $display("FAIL midreset_framecnt got %h want 1",
                  (obs.size() > 0) ? obs[0].fc : 16'h0);
      end
   endtask

   initial begin
      test_reset();
      test_skip_capture();
      test_swap();
      test_crop();
      test_partial_line();
      test_random();
      test_en_drop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
